// File: rtl/alu_issue_if.sv
// alu_issue_if: decode, forwarding, load-hazard and issue signals of the ALU issue stage
interface alu_issue_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
);
    logic            flush;
    logic            dec_valid;
    logic            dec_ready;
    logic [3:0]      dec_ctl;
    logic [REGW-1:0] dec_rs1;
    logic [REGW-1:0] dec_rs2;
    logic [XLEN-1:0] dec_rs1_val;
    logic [XLEN-1:0] dec_rs2_val;
    logic [XLEN-1:0] dec_imm;
    logic            dec_use_imm;
    logic [REGW-1:0] dec_rd;
    logic            dec_wen;
    logic            ex_fwd_wen;
    logic [REGW-1:0] ex_fwd_rd;
    logic [XLEN-1:0] ex_fwd_data;
    logic            wb_fwd_wen;
    logic [REGW-1:0] wb_fwd_rd;
    logic [XLEN-1:0] wb_fwd_data;
    logic            ld_pending;
    logic [REGW-1:0] ld_rd;
    logic            iss_valid;
    logic            iss_ready;
    logic [3:0]      alu_ctl;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [REGW-1:0] iss_rd;
    logic            iss_wen;
    logic            iss_illegal;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        output flush, dec_valid, dec_ctl, dec_rs1, dec_rs2, dec_rs1_val, dec_rs2_val,
               dec_imm, dec_use_imm, dec_rd, dec_wen, ex_fwd_wen, ex_fwd_rd, ex_fwd_data,
               wb_fwd_wen, wb_fwd_rd, wb_fwd_data, ld_pending, ld_rd, iss_ready,
        input  dec_ready, iss_valid, alu_ctl, alu_a, alu_b, iss_rd, iss_wen, iss_illegal,
               stall_cnt
    );

    modport slave (
        input  flush, dec_valid, dec_ctl, dec_rs1, dec_rs2, dec_rs1_val, dec_rs2_val,
               dec_imm, dec_use_imm, dec_rd, dec_wen, ex_fwd_wen, ex_fwd_rd, ex_fwd_data,
               wb_fwd_wen, wb_fwd_rd, wb_fwd_data, ld_pending, ld_rd, iss_ready,
        output dec_ready, iss_valid, alu_ctl, alu_a, alu_b, iss_rd, iss_wen, iss_illegal,
               stall_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-to-execute register resolving ALU operands with forwarding,
// shift/rotate fix-ups, load-use stalls and a valid/ready handshake on both sides.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);
    logic [XLEN-1:0] a_res, b_reg, b_res, b_fix;
    logic [4:0]      n, n_neg;
    logic            hz, cap;

    always_comb begin
        a_res = bus.dec_rs1 == REGW'(0) ? '0 :
                (bus.ex_fwd_wen && bus.ex_fwd_rd == bus.dec_rs1) ? bus.ex_fwd_data :
                (bus.wb_fwd_wen && bus.wb_fwd_rd == bus.dec_rs1) ? bus.wb_fwd_data :
                bus.dec_rs1_val;
        b_reg = bus.dec_rs2 == REGW'(0) ? '0 :
                (bus.ex_fwd_wen && bus.ex_fwd_rd == bus.dec_rs2) ? bus.ex_fwd_data :
                (bus.wb_fwd_wen && bus.wb_fwd_rd == bus.dec_rs2) ? bus.wb_fwd_data :
                bus.dec_rs2_val;
        b_res = bus.dec_use_imm ? bus.dec_imm : b_reg;
        n     = b_res[4:0];
        // ALU only rotates left, so ror by n becomes rol by (32-n) mod 32
        n_neg = 5'd0 - n;
        b_fix = (bus.dec_ctl == 4'd3 || bus.dec_ctl == 4'd4 || bus.dec_ctl == 4'd6) ?
                {{(XLEN-5){1'b0}}, n} :
                bus.dec_ctl == 4'd5 ? {{(XLEN-5){1'b0}}, n_neg} : b_res;
        hz    = bus.dec_valid && bus.ld_pending && bus.ld_rd != REGW'(0) &&
                (bus.ld_rd == bus.dec_rs1 || (!bus.dec_use_imm && bus.ld_rd == bus.dec_rs2));
        bus.dec_ready = bus.flush || (!hz && (!bus.iss_valid || bus.iss_ready));
        cap   = bus.dec_valid && bus.dec_ready && !bus.flush;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.iss_valid   <= 1'b0;
            bus.alu_ctl     <= '0;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.iss_rd      <= '0;
            bus.iss_wen     <= 1'b0;
            bus.iss_illegal <= 1'b0;
            bus.stall_cnt   <= '0;
        end else begin
            if (bus.flush) begin
                bus.iss_valid <= 1'b0;
            end else if (cap) begin
                bus.iss_valid   <= 1'b1;
                bus.alu_ctl     <= bus.dec_ctl;
                bus.alu_a       <= a_res;
                bus.alu_b       <= b_fix;
                bus.iss_rd      <= bus.dec_rd;
                bus.iss_wen     <= bus.dec_wen;
                bus.iss_illegal <= bus.dec_ctl > 4'd6;
            end else if (bus.iss_ready) begin
                bus.iss_valid <= 1'b0;
            end
            if (hz && !bus.flush && bus.stall_cnt != '1)
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed plus random stimulus against a behavioural model of the issue stage
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_issue_if bus ();
    alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    bit          m_valid, m_wen, m_ill;
    logic [3:0]  m_ctl;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;
    int          m_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return 32'd0;
        if (bus.ex_fwd_wen && bus.ex_fwd_rd == r) return bus.ex_fwd_data;
        if (bus.wb_fwd_wen && bus.wb_fwd_rd == r) return bus.wb_fwd_data;
        return rf;
    endfunction

    function automatic logic [31:0] fix_b(input int ctl, input logic [31:0] b);
        int n = int'(b % 32);
        case (ctl)
            3, 4, 6: return n;
            5:       return (32 - n) % 32;
            default: return b;
        endcase
    endfunction

    task automatic idle();
        bus.flush = 0; bus.dec_valid = 0; bus.dec_ctl = 0;
        bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rs1_val = 0; bus.dec_rs2_val = 0;
        bus.dec_imm = 0; bus.dec_use_imm = 0; bus.dec_rd = 0; bus.dec_wen = 0;
        bus.ex_fwd_wen = 0; bus.ex_fwd_rd = 0; bus.ex_fwd_data = 0;
        bus.wb_fwd_wen = 0; bus.wb_fwd_rd = 0; bus.wb_fwd_data = 0;
        bus.ld_pending = 0; bus.ld_rd = 0; bus.iss_ready = 1;
    endtask

    // Inputs are already applied (just after a negedge); check ready, advance model one edge, check outputs.
    task automatic step();
        bit hz, rdy, cap;
        logic [31:0] na, nb;
        hz  = bus.dec_valid && bus.ld_pending && bus.ld_rd != 0 &&
              (bus.ld_rd == bus.dec_rs1 || (!bus.dec_use_imm && bus.ld_rd == bus.dec_rs2));
        rdy = bus.flush || (!hz && (!m_valid || bus.iss_ready));
        #1;
        check("dec_ready", bus.dec_ready, rdy);
        cap = bus.dec_valid && rdy && !bus.flush;
        na  = resolve(bus.dec_rs1, bus.dec_rs1_val);
        nb  = fix_b(bus.dec_ctl, bus.dec_use_imm ? bus.dec_imm : resolve(bus.dec_rs2, bus.dec_rs2_val));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_ctl = 0; m_a = 0; m_b = 0; m_rd = 0; m_wen = 0; m_ill = 0; m_stall = 0;
        end else begin
            if (hz && !bus.flush && m_stall < 65535) m_stall++;
            if (bus.flush) m_valid = 0;
            else if (cap) begin
                m_valid = 1; m_ctl = bus.dec_ctl; m_a = na; m_b = nb;
                m_rd = bus.dec_rd; m_wen = bus.dec_wen; m_ill = bus.dec_ctl > 6;
            end else if (bus.iss_ready) m_valid = 0;
        end
        @(negedge clk);
        check("iss_valid", bus.iss_valid, m_valid);
        check("alu_ctl", bus.alu_ctl, m_ctl);
        check("alu_a", bus.alu_a, m_a);
        check("alu_b", bus.alu_b, m_b);
        check("iss_rd", bus.iss_rd, m_rd);
        check("iss_wen", bus.iss_wen, m_wen);
        check("iss_illegal", bus.iss_illegal, m_ill);
        check("stall_cnt", bus.stall_cnt, m_stall);
    endtask

    task automatic issue_imm(input logic [3:0] ctl, input logic [31:0] imm);
        idle();
        bus.dec_valid = 1; bus.dec_ctl = ctl; bus.dec_use_imm = 1; bus.dec_imm = imm;
        bus.dec_rd = 7; bus.dec_wen = 1;
        step();
    endtask

    initial begin
        m_valid = 0; m_ctl = 0; m_a = 0; m_b = 0; m_rd = 0; m_wen = 0; m_ill = 0; m_stall = 0;
        idle();
        @(negedge clk);
        step(); step();
        check("rst_valid", bus.iss_valid, 0);
        check("rst_stall", bus.stall_cnt, 0);

        rst_n = 1;
        idle();
        bus.dec_valid = 1; bus.dec_rs1 = 3; bus.dec_rs1_val = 5; bus.dec_use_imm = 1; bus.dec_imm = 7;
        bus.dec_rd = 9; bus.dec_wen = 1;
        step();
        check("add_valid", bus.iss_valid, 1);
        check("add_a", bus.alu_a, 5);
        check("add_b", bus.alu_b, 7);
        idle();
        rst_n = 0;
        step();
        check("rst_mid_valid", bus.iss_valid, 0);
        check("rst_mid_a", bus.alu_a, 0);
        rst_n = 1;

        idle();
        bus.dec_valid = 1; bus.dec_rs1 = 4; bus.dec_rs1_val = 32'h11;
        bus.wb_fwd_wen = 1; bus.wb_fwd_rd = 4; bus.wb_fwd_data = 32'h22;
        bus.ex_fwd_wen = 1; bus.ex_fwd_rd = 4; bus.ex_fwd_data = 32'h33;
        step();
        check("fwd_ex", bus.alu_a, 32'h33);
        bus.ex_fwd_wen = 0;
        step();
        check("fwd_wb", bus.alu_a, 32'h22);
        bus.dec_rs1 = 0; bus.ex_fwd_wen = 1; bus.ex_fwd_rd = 0;
        step();
        check("fwd_r0", bus.alu_a, 0);

        issue_imm(5, 8);         check("ror8", bus.alu_b, 24);
        issue_imm(5, 0);         check("ror0", bus.alu_b, 0);
        issue_imm(6, 32'h25);    check("rol25", bus.alu_b, 5);
        issue_imm(3, 33);        check("lsl33", bus.alu_b, 1);
        issue_imm(9, 32'h1234);  check("ill_flag", bus.iss_illegal, 1);
        check("ill_b", bus.alu_b, 32'h1234);

        idle();
        step();
        bus.dec_valid = 1; bus.dec_rs1 = 1; bus.dec_rs2 = 2; bus.ld_pending = 1; bus.ld_rd = 2;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hz_ready", bus.dec_ready, 0);
            check("hz_nocap", bus.iss_valid, 0);
        end
        check("hz_stall", bus.stall_cnt, 3);
        bus.dec_use_imm = 1; bus.dec_imm = 32'h55;
        #1 check("imm_nohz", bus.dec_ready, 1);
        step();
        check("imm_cap", bus.iss_valid, 1);

        idle();
        bus.dec_valid = 1; bus.iss_ready = 0; bus.dec_use_imm = 1; bus.dec_imm = 32'hAB;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_b", bus.alu_b, 32'h55);
        end
        bus.iss_ready = 1;
        step();
        check("b2b_valid", bus.iss_valid, 1);
        check("b2b_b", bus.alu_b, 32'hAB);

        bus.flush = 1; bus.dec_imm = 32'hCD;
        #1 check("flush_ready", bus.dec_ready, 1);
        step();
        check("flush_valid", bus.iss_valid, 0);
        check("flush_keep_b", bus.alu_b, 32'hAB);
        bus.dec_use_imm = 0; bus.dec_rs2 = 2; bus.ld_pending = 1; bus.ld_rd = 2;
        step();
        check("flush_hz_stall", bus.stall_cnt, 3);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(63) != 0);
            bus.flush = ($urandom_range(9) == 0);
            bus.dec_valid = $urandom_range(1);
            bus.dec_ctl = 4'($urandom_range(15));
            bus.dec_rs1 = 5'($urandom_range(3));
            bus.dec_rs2 = 5'($urandom_range(3));
            bus.dec_rs1_val = $urandom;
            bus.dec_rs2_val = $urandom;
            bus.dec_imm = $urandom;
            bus.dec_use_imm = $urandom_range(1);
            bus.dec_rd = 5'($urandom);
            bus.dec_wen = $urandom_range(1);
            bus.ex_fwd_wen = $urandom_range(1);
            bus.ex_fwd_rd = 5'($urandom_range(3));
            bus.ex_fwd_data = $urandom;
            bus.wb_fwd_wen = $urandom_range(1);
            bus.wb_fwd_rd = 5'($urandom_range(3));
            bus.wb_fwd_data = $urandom;
            bus.ld_pending = ($urandom_range(3) == 0);
            bus.ld_rd = 5'($urandom_range(3));
            bus.iss_ready = ($urandom_range(3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
